// File: rtl/chunked_seq_adder_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM state encoding
// and the sizing helper for the chunk counter.
package chunked_seq_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for n chunks; never narrower than one bit so NCHUNK==1 still works.
  function automatic int cnt_width(input int n);
    int w;
    if (n <= 2) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/chunked_seq_adder_ripple_carry_adder.sv
// Plain ripple-carry adder used as the per-cycle slice of the chunked adder.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry_s;

  // Full-adder chain, LSB first.
  always_comb begin
    carry_s    = {(WIDTH+1){1'b0}};
    sum        = {WIDTH{1'b0}};
    carry_s[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry_s[WIDTH];

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/subtract unit: processes CHUNK bits per cycle through one
// shared ripple-carry slice, with valid/ready handshakes on both sides.
// Subtraction is done as a + ~b + ~cin, so cout=1 means "no borrow".
module chunked_seq_adder
  import chunked_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = cnt_width(NCHUNK);

  state_t           state_r;
  logic [KW-1:0]    k_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic             a_msb_r;
  logic             b_msb_r;

  logic [CHUNK-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic [WIDTH-1:0] res_next_s;
  logic             accept_s;
  logic             last_s;

  ripple_carry_adder #(.WIDTH(CHUNK)) u_slice (
    .a    (a_r[CHUNK-1:0]),
    .b    (b_r[CHUNK-1:0]),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // A new op may enter when idle, or when the held result retires this cycle.
  assign in_ready = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
  assign accept_s = in_valid & in_ready;
  assign last_s   = (k_r == KW'(NCHUNK - 1));

  // Result register fills from the top, so after NCHUNK slices it holds the full sum.
  assign res_next_s = (res_r >> CHUNK) | (WIDTH'(slice_sum_s) << (WIDTH - CHUNK));

  // FSM, operand shifters, chunk counter and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      k_r       <= {KW{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      res_r     <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      a_msb_r   <= 1'b0;
      b_msb_r   <= 1'b0;
      sum       <= {WIDTH{1'b0}};
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_BUSY: begin
          carry_r <= slice_cout_s;
          a_r     <= a_r >> CHUNK;
          b_r     <= b_r >> CHUNK;
          res_r   <= res_next_s;
          if (last_s) begin
            sum       <= res_next_s;
            cout      <= slice_cout_s;
            overflow  <= (a_msb_r == b_msb_r) & (res_next_s[WIDTH-1] != a_msb_r);
            out_valid <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase

      // Accept overrides the IDLE/DONE next state; a retire-and-accept goes straight to BUSY.
      if (accept_s) begin
        a_r     <= a;
        b_r     <= op_sub ? ~b : b;
        carry_r <= op_sub ? ~cin : cin;
        a_msb_r <= a[WIDTH-1];
        b_msb_r <= op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
        res_r   <= {WIDTH{1'b0}};
        k_r     <= {KW{1'b0}};
        state_r <= ST_BUSY;
      end
    end
  end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Self-checking bench for chunked_seq_adder (WIDTH=16, CHUNK=4): directed
// vector table, backpressure and mid-op reset sequences, then a randomized
// regression against an integer-arithmetic reference model.
module tb_chunked_seq_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int NOPS   = 10000;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  vec_t vecs [6];
  res_t exp_q [$];

  chunked_seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operand values.
  function automatic res_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                 input logic tc, input logic ts);
    res_t r;
    int ua, ub, sa, sb, c, ur, sr;
    ua = int'(ta);
    ub = int'(tb);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    c  = tc ? 1 : 0;
    if (ts) begin
      ur     = ua - ub - c;
      sr     = sa - sb - c;
      r.cout = (ur >= 0);
    end else begin
      ur     = ua + ub + c;
      sr     = sa + sb + c;
      r.cout = (ur >= 65536);
    end
    r.sum = ur[WIDTH-1:0];
    r.ovf = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  task automatic drive_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc, input logic ts);
    a        = ta;
    b        = tb;
    cin      = tc;
    op_sub   = ts;
    in_valid = 1'b1;
  endtask

  // One op from IDLE with out_ready high: exact latency, values, then retire.
  task automatic run_vec(input vec_t v);
    out_ready = 1'b1;
    drive_op(v.a, v.b, v.cin, v.sub);
    #1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("valid_after_accept", {31'd0, out_valid}, 32'd0);
    for (int c = 1; c < NCHUNK; c++) begin
      @(posedge clk); #1;
      chk("valid_early", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    chk("valid_at_latency", {31'd0, out_valid}, 32'd1);
    chk("sum", {16'd0, sum}, {16'd0, v.exp_sum});
    chk("cout", {31'd0, cout}, {31'd0, v.exp_cout});
    chk("overflow", {31'd0, overflow}, {31'd0, v.exp_ovf});
    @(posedge clk); #1;
    chk("valid_after_retire", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int accepted, retired, cycles;
    logic acc, ret;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs;
    res_t e;

    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    cin       = 1'b0;
    op_sub    = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, overflow}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure: result held 3 cycles, then retire-and-accept in one cycle.
    out_ready = 1'b0;
    drive_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(10, "bp_first_valid");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_sum_held", {16'd0, sum}, 32'h3333);
      chk("bp_flags_held", {30'd0, cout, overflow}, 32'd0);
    end
    out_ready = 1'b1;
    drive_op(16'h0010, 16'h0003, 1'b0, 1'b1);
    #1;
    chk("bp_in_ready_retire", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_valid_dropped", {31'd0, out_valid}, 32'd0);
    for (int c = 1; c < NCHUNK; c++) begin
      @(posedge clk); #1;
      chk("bp2_valid_early", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    chk("bp2_valid", {31'd0, out_valid}, 32'd1);
    chk("bp2_sum", {16'd0, sum}, 32'h000D);
    chk("bp2_flags", {30'd0, cout, overflow}, 32'd2);
    @(posedge clk); #1;

    // Reset at k=2: partial op discarded, no result emerges.
    drive_op(16'hABCD, 16'h1234, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {16'd0, sum}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < NCHUNK + 2; c++) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run_vec(vecs[1]);

    // Randomized regression with random handshakes.
    accepted = 0;
    retired  = 0;
    cycles   = 0;
    while (retired < NOPS && cycles < 80000) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      a         = ra;
      b         = rb;
      cin       = rc;
      op_sub    = rs;
      in_valid  = (accepted < NOPS) && ($urandom_range(7, 0) != 0);
      out_ready = ($urandom_range(7, 0) != 0);
      #1;
      acc = in_valid & in_ready;
      ret = out_valid & out_ready;
      if (ret) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_sum", {16'd0, sum}, {16'd0, e.sum});
          chk("rand_cout", {31'd0, cout}, {31'd0, e.cout});
          chk("rand_ovf", {31'd0, overflow}, {31'd0, e.ovf});
        end
        retired++;
      end
      if (acc) begin
        exp_q.push_back(model(ra, rb, rc, rs));
        accepted++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    chk("rand_ops_retired", retired, NOPS);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
